// File: rtl/p10_prm_pkg.sv
// Shared types for the parameter access controller: ROM descriptor layout,
// access rights, response status codes and the fixed parameter map.
package p10_prm_pkg;

    localparam int PRM_VAL_W = 32;

    typedef enum logic [1:0] {
        ACC_RW = 2'd0,
        ACC_RO = 2'd1,
        ACC_WO = 2'd2
    } prm_access_t;

    typedef struct packed {
        logic [PRM_VAL_W-1:0] min_val;
        logic [PRM_VAL_W-1:0] max_val;
        prm_access_t          access;
        logic                 is_exec;
    } prm_entry_t;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_BAD_ADDR = 2'd1;
    localparam logic [1:0] ST_DENIED   = 2'd2;
    localparam logic [1:0] ST_RANGE    = 2'd3;

    localparam int ADDR_FREQ_HZ      = 0;
    localparam int ADDR_DUTY_PERCENT = 1;
    localparam int ADDR_PHASE_DEGREE = 2;
    localparam int ADDR_APPLY        = 3;
    localparam int ADDR_VERSION      = 4;
    localparam int ADDR_KEY          = 5;

endpackage

// File: rtl/p10_prm_ctrl.sv
// Parameter ROM / value register access controller: one request at a time.
// Build option P10_PRM_CLAMP_EN: out-of-range non-exec writes saturate and store.
//
// state | meaning
// IDLE  | ready for a request, captures write/addr/data on accept
// FETCH | ROM address issued, waiting for the registered descriptor
// CHECK | descriptor valid: rights, range and exec evaluation
// RESP  | response held until rsp_ready
module p10_prm_ctrl
    import p10_prm_pkg::*;
#(
    parameter int PRM_COUNT = 8,
    parameter int VAL_W     = PRM_VAL_W,
    localparam int AW       = $clog2(PRM_COUNT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [AW-1:0]            req_addr,
    input  logic [VAL_W-1:0]         req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_status,
    output logic [VAL_W-1:0]         rsp_data,
    output logic [AW-1:0]            rom_addr,
    input  prm_entry_t               rom_entry,
    output logic [PRM_COUNT*VAL_W-1:0] prm_values,
    output logic [PRM_COUNT-1:0]     exec_strobe
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CHECK, S_RESP} state_t;

    state_t state, state_nxt;

    logic             wr_q;
    logic [AW-1:0]    addr_q;
    logic [VAL_W-1:0] data_q;
    logic [VAL_W-1:0] values [PRM_COUNT];
    logic [VAL_W-1:0] cur_val;
    logic             addr_bad;
    logic             in_range;
    logic [1:0]       chk_status;
    logic [VAL_W-1:0] chk_data;
    logic             chk_store;
    logic             chk_fire;

    assign addr_bad = (req_addr >= AW'(PRM_COUNT));
    assign in_range = (data_q >= rom_entry.min_val) && (data_q <= rom_entry.max_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = addr_bad ? S_RESP : S_FETCH;
            end
            S_FETCH: state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < PRM_COUNT; i++)
            if (addr_q == AW'(i)) cur_val = values[i];
    end

    // Rights first, then read, then exec write, then ranged write.
    always_comb begin
        chk_status = ST_OK;
        chk_data   = '0;
        chk_store  = 1'b0;
        chk_fire   = 1'b0;
        if ((wr_q && rom_entry.access == ACC_RO) || (!wr_q && rom_entry.access == ACC_WO)) begin
            chk_status = ST_DENIED;
        end else if (!wr_q) begin
            chk_data = rom_entry.is_exec ? '0 : cur_val;
        end else if (rom_entry.is_exec) begin
            if (data_q > VAL_W'(1)) chk_status = ST_RANGE;
            else                    chk_fire   = data_q[0];
        end else if (in_range) begin
            chk_store = 1'b1;
            chk_data  = data_q;
        end else begin
            chk_status = ST_RANGE;
`ifdef P10_PRM_CLAMP_EN
            chk_store = 1'b1;
            chk_data  = (data_q < rom_entry.min_val) ? rom_entry.min_val : rom_entry.max_val;
`else
            chk_data  = cur_val;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rom_addr    <= '0;
            rsp_status  <= '0;
            rsp_data    <= '0;
            exec_strobe <= '0;
            for (int i = 0; i < PRM_COUNT; i++) values[i] <= '0;
        end else begin
            exec_strobe <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q   <= req_write;
                        addr_q <= req_addr;
                        data_q <= req_data;
                        if (addr_bad) begin
                            rsp_status <= ST_BAD_ADDR;
                            rsp_data   <= '0;
                        end else begin
                            rom_addr <= req_addr;
                        end
                    end
                end
                S_CHECK: begin
                    rsp_status <= chk_status;
                    rsp_data   <= chk_data;
                    // Strobe lands on the first cycle of RESP.
                    for (int i = 0; i < PRM_COUNT; i++) begin
                        if (addr_q == AW'(i)) begin
                            if (chk_store) values[i] <= chk_data;
                            exec_strobe[i] <= chk_fire;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < PRM_COUNT; g++) begin : g_values
        assign prm_values[g*VAL_W +: VAL_W] = values[g];
    end

endmodule

// File: doc/p10_prm_ctrl.md
Name: p10_prm_ctrl

Overview:
- Access controller for the parameter ROM and the parameter value registers.
- Accepts one read or write request at a time from a host command parser (UART/CLI side). Fetches the parameter's ROM descriptor and checks access rights and the min/max range.
- Updates the internal value register, or fires an exec strobe for command-type parameters, then returns a status/data response.
- Drives the ROM address port and exposes all stored values to the PWM datapath.

Parameters:
- PRM_COUNT, 8, number of parameter slots; must match the ROM.
- VAL_W, 32, width of parameter values, request data and response data.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  $clog2(PRM_COUNT+1)  parameter address
- req_data  in  VAL_W  write value
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_status  out  2  0 OK, 1 BAD_ADDR, 2 DENIED, 3 RANGE
- rsp_data  out  VAL_W  read value, or stored value after a write
- rom_addr  out  $clog2(PRM_COUNT+1)  address to the parameter ROM
- rom_entry  in  prm_entry_t  ROM descriptor, registered, valid 1 cycle after rom_addr
- prm_values  out  PRM_COUNT*VAL_W  flattened value registers; slot i at [i*VAL_W +: VAL_W]
- exec_strobe  out  PRM_COUNT  one-cycle pulse per exec parameter

Behaviour:
- Clock is clk; reset rst is asynchronous, active-high.
- Reset state: FSM in IDLE; all value registers, rsp_data, rsp_status, rom_addr and exec_strobe = 0; rsp_valid = 0; req_ready = 1.
- FSM states: IDLE, FETCH, CHECK, RESP.
- IDLE: req_ready = 1. On req_valid, capture write, addr and data.
  - If addr >= PRM_COUNT: go to RESP with BAD_ADDR and rsp_data = 0. rsp_valid rises 1 cycle after accept.
  - Otherwise: rom_addr <= addr; go to FETCH.
- FETCH: wait one cycle for the registered ROM output; go to CHECK.
- CHECK: rom_entry is valid here. Evaluate in priority order:
  - Rights: a write to an ro entry, or a read from a wo entry, gives DENIED. The register is unchanged and rsp_data = 0.
  - Read: rsp_data = register value; exec entries always read 0. Status OK.
  - Write, non-exec: unsigned compare min <= data <= max. In range: store the value, status OK, rsp_data = new value. Out of range: RANGE, register unchanged, rsp_data = old value.
  - Write, exec: data must be 0 or 1, otherwise RANGE. A value of 1 pulses exec_strobe[addr] for exactly one cycle, coincident with the first rsp_valid cycle. Exec entries never store; status OK.
  - Then go to RESP.
- RESP: rsp_valid = 1, with status and data held stable until rsp_ready. The handshake cycle returns the FSM to IDLE. req_ready = 0 in all states other than IDLE.
- Latency: accept to rsp_valid is 3 cycles for valid addresses and 1 cycle for BAD_ADDR. Back-to-back throughput is one request per 4 cycles when rsp_ready is held high.
- prm_values updates on the clock edge that leaves CHECK, and is visible to the datapath before the response completes.
- Only one transaction is in flight, so simultaneous-request cases cannot arise.
- Asserting rst mid-transaction aborts it: no strobe, no register write, rsp_valid drops immediately.
- Data is captured at accept; later changes on req_data are ignored.

Optional Feature:
- Macro: P10_PRM_CLAMP_EN.
- Defined: an out-of-range non-exec write is saturated to min or max and stored. Status is still 3 (meaning "clamped") and rsp_data = the stored clamped value. Exec entries keep the RANGE rejection.
- Undefined: behaviour as specified above; out-of-range writes are rejected and the register is unchanged.

Test Plan:
- Write ADDR_FREQ_HZ = 100000 -> rsp_status 0, rsp_data 100000, prm_values slot updated, rsp_valid 3 cycles after accept.
- Write ADDR_FREQ_HZ = 600000 -> status 3, slot stays 100000. With P10_PRM_CLAMP_EN: slot = 500000, rsp_data 500000.
- Write ADDR_APPLY = 1 -> exec_strobe[ADDR_APPLY] high exactly 1 cycle, status 0. Subsequent read of ADDR_APPLY returns 0. Write ADDR_APPLY = 2 -> status 3, no strobe.
- Read req_addr = 8 with PRM_COUNT = 8 -> status 1, rsp_data 0, rsp_valid 1 cycle after accept, rom_addr unchanged.
- Write ADDR_DUTY_PERCENT = 25, hold rsp_ready low 5 cycles -> rsp_valid, status and data stable throughout, req_ready 0. Handshake, then req_ready 1 the next cycle.
- Assert rst during FETCH of a write ADDR_PHASE_DEGREE = 90 -> slot stays 0, rsp_valid 0, FSM in IDLE, no strobe.
